cpu_pio_1_arbiter: RTL and testbench
====================================

CPU_PIO_1_ARBITER -- requirements
Module: cpu_pio_1_arbiter

Interface
REQ-001 SHALL provide parameter READBACK, default 1: 1 = read back and check every write; 0 = write only.
REQ-002 SHALL provide parameter CNT_W, default 8: width of the write counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a 29-bit value to output.
REQ-006 req0_data  input  29  requester 0 value.
REQ-007 req0_ready  output  1  one-cycle accept strobe for requester 0.
REQ-008 req1_valid  input  1  requester 1 has a value to output.
REQ-009 req1_data  input  29  requester 1 value.
REQ-010 req1_ready  output  1  one-cycle accept strobe for requester 1.
REQ-011 avm_address  output  2  PIO slave address; always 0.
REQ-012 avm_chipselect  output  1  PIO slave select.
REQ-013 avm_write_n  output  1  PIO slave write strobe, active-low.
REQ-014 avm_writedata  output  32  {3'b000, latched 29-bit value}.
REQ-015 avm_readdata  input  32  PIO slave readdata; combinational, valid in the same cycle as the address.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 last_grant  output  1  index of the most recently granted requester.
REQ-018 mismatch  output  1  sticky readback error flag.
REQ-019 wr_count  output  CNT_W  number of completed slave writes; saturates at all-ones.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ; one state per cycle, no wait states.
REQ-021 IDLE, no valid input: remain in IDLE; chipselect=0, write_n=1.
REQ-022 IDLE, exactly one valid: grant that requester; its ready=1 for that cycle; latch its data; go to WRITE.
REQ-023 IDLE, both valid: grant requester != last_grant (round robin); the other ready stays 0 and its request is held for a later cycle.
REQ-024 At most one ready SHALL be high in any cycle; ready SHALL only assert in IDLE with the matching valid=1.
REQ-025 On grant, last_grant SHALL update to the granted index in the same edge that leaves IDLE.
REQ-026 WRITE: chipselect=1, write_n=0, address=0, writedata={3'b0, latched}; exactly one cycle; wr_count increments unless saturated.
REQ-027 WRITE exit: next state is READ if READBACK=1, otherwise IDLE.
REQ-028 READ: chipselect=1, write_n=1, address=0; sample avm_readdata; if readdata[28:0] != latched value or readdata[31:29] != 0, set mismatch; next state IDLE.
REQ-029 mismatch SHALL stay set until reset; later matching reads SHALL NOT clear it.
REQ-030 Grant-to-write latency is 1 cycle; throughput is 1 write per 3 cycles (READBACK=1) or 2 cycles (READBACK=0).
REQ-031 Valid deasserting while not granted SHALL be legal; the request is dropped with no side effect.
REQ-032 Input data SHALL be sampled only on the grant cycle; later input changes SHALL NOT affect the write in progress.
REQ-033 Outside WRITE and READ: chipselect=0, write_n=1, writedata=0.

Reset
REQ-034 reset=1 SHALL force, asynchronously: state IDLE; chipselect=0; write_n=1; address=0; writedata=0; ready outputs 0; busy=0; last_grant=1 (requester 0 wins the first tie); mismatch=0; wr_count=0; latched value=0.
REQ-035 Reset asserted in WRITE or READ SHALL abort the transaction immediately; no ready pulse, counter update or mismatch update for it.
REQ-036 After reset deasserts, the first grant SHALL occur no earlier than the next rising edge.

Verification
REQ-037 Single request: req0_valid=1, data=29'h1ABCDEF0, slave model echoes -> req0_ready pulse 1 cycle; next cycle write with writedata=32'h1ABCDEF0; then READ; mismatch=0; wr_count=1.
REQ-038 Tie after reset: both valid held for 6 cycles -> grants 0,1 alternating (req0 first); writes of req0_data, req1_data, req0_data...; never both ready.
REQ-039 Readback error: slave model returns 32'h00000001 when 32'h00000002 was written -> mismatch=1 after READ; a later correct write leaves mismatch=1.
REQ-040 READBACK=0: req1 held valid -> chipselect pattern write, idle, write...; no read cycles; 2-cycle period.
REQ-041 Saturation: CNT_W=2, 5 writes -> wr_count 1,2,3,3,3.
REQ-042 Reset mid-WRITE: assert reset during WRITE -> chipselect drops asynchronously; state IDLE; wr_count unchanged from its pre-transaction value (or 0 if reset clears it); last_grant=1.

Source files
------------

// File: rtl/cpu_pio_1_arbiter_if.sv
// Requester handshakes and the single-word PIO slave port of cpu_pio_1_arbiter.
// The arbiter is the bus master; the slave modport is the requesters/PIO side.
interface cpu_pio_1_arbiter_if;
  logic        req0_valid;
  logic [28:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [28:0] req1_data;
  logic        req1_ready;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, avm_readdata,
    output req0_ready, req1_ready,
           avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, avm_readdata,
    input  req0_ready, req1_ready,
           avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/cpu_pio_1_arbiter.sv
// Round-robin arbiter between two 29-bit requesters feeding one PIO slave register,
// with optional read-back verification of every write and a saturating write counter.
module cpu_pio_1_arbiter #(
  parameter int READBACK = 1,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_pio_1_arbiter_if.master  bus,
  output logic                 busy,
  output logic                 last_grant,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] latched_q;
  logic        grant_vld;
  logic        grant_idx;

  // Tie goes to the requester that did not win last; last_grant resets to 1 so req0 wins first.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_idx = ~last_grant;
    else                                  grant_idx = bus.req1_valid;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d            = state_q;
    bus.req0_ready     = 1'b0;
    bus.req1_ready     = 1'b0;
    bus.avm_address    = 2'b00;
    bus.avm_chipselect = 1'b0;
    bus.avm_write_n    = 1'b1;
    bus.avm_writedata  = 32'h0;

    unique case (state_q)
      IDLE: begin
        // Ready is combinational, so it is gated by reset to stay low while reset is held.
        if (grant_vld && !reset) begin
          bus.req0_ready = ~grant_idx;
          bus.req1_ready = grant_idx;
          state_d        = WRITE;
        end
      end
      WRITE: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_write_n    = 1'b0;
        bus.avm_writedata  = {3'b000, latched_q};
        state_d            = (READBACK != 0) ? READ : IDLE;
      end
      READ: begin
        bus.avm_chipselect = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      latched_q  <= 29'h0;
      last_grant <= 1'b1;
      mismatch   <= 1'b0;
      wr_count   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && grant_vld) begin
        latched_q  <= grant_idx ? bus.req1_data : bus.req0_data;
        last_grant <= grant_idx;
      end

      if (state_q == WRITE && wr_count != {CNT_W{1'b1}})
        wr_count <= wr_count + CNT_W'(1);

      // Sticky: only reset clears it; the upper three bits must read back as zero too.
      if (state_q == READ && bus.avm_readdata != {3'b000, latched_q})
        mismatch <= 1'b1;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_pio_1_arbiter.sv
// Scoreboard bench for cpu_pio_1_arbiter: a readback instance with an echoing slave,
// and a write-only instance with a 2-bit counter.
module tb_cpu_pio_1_arbiter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic corrupt;

  always #5 clk = ~clk;

  cpu_pio_1_arbiter_if bus_a ();
  cpu_pio_1_arbiter_if bus_b ();

  logic       busy_a, last_grant_a, mismatch_a;
  logic [7:0] wr_count_a;
  logic       busy_b, last_grant_b, mismatch_b;
  logic [1:0] wr_count_b;

  cpu_pio_1_arbiter #(.READBACK(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .busy(busy_a), .last_grant(last_grant_a), .mismatch(mismatch_a), .wr_count(wr_count_a)
  );

  cpu_pio_1_arbiter #(.READBACK(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .busy(busy_b), .last_grant(last_grant_b), .mismatch(mismatch_b), .wr_count(wr_count_b)
  );

  // Slave model: one register, echoed on reads unless corruption is forced.
  logic [31:0] slave_reg_a = 32'h0;
  always @(posedge clk)
    if (bus_a.avm_chipselect && !bus_a.avm_write_n) slave_reg_a <= bus_a.avm_writedata;
  assign bus_a.avm_readdata = corrupt ? 32'h0000_0001 : slave_reg_a;
  assign bus_b.avm_readdata = 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  bit          grant_q[$];

  always @(negedge clk) begin
    if (bus_a.req0_ready || bus_a.req1_ready) begin
      check("a_one_ready", {63'b0, bus_a.req0_ready & bus_a.req1_ready}, 64'd0);
      if (bus_a.req0_ready) begin
        check("a_rdy0_valid", {63'b0, bus_a.req0_valid}, 64'd1);
        exp_a.push_back({3'b000, bus_a.req0_data});
        grant_q.push_back(1'b0);
      end else begin
        check("a_rdy1_valid", {63'b0, bus_a.req1_valid}, 64'd1);
        exp_a.push_back({3'b000, bus_a.req1_data});
        grant_q.push_back(1'b1);
      end
    end
    if (bus_a.avm_chipselect && !bus_a.avm_write_n) begin
      if (exp_a.size() == 0) check("a_sb_underflow", 64'd1, 64'd0);
      else                   check("a_wdata", {32'b0, bus_a.avm_writedata}, {32'b0, exp_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (bus_b.req1_ready) exp_b.push_back({3'b000, bus_b.req1_data});
    if (bus_b.req0_ready) check("b_rdy0_unexpected", 64'd1, 64'd0);
    if (bus_b.avm_chipselect && bus_b.avm_write_n) check("b_no_read_cycle", 64'd1, 64'd0);
    if (bus_b.avm_chipselect && !bus_b.avm_write_n) begin
      if (exp_b.size() == 0) check("b_sb_underflow", 64'd1, 64'd0);
      else                   check("b_wdata", {32'b0, bus_b.avm_writedata}, {32'b0, exp_b.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Entered and left at posedge+1: request once, drop valid after the grant, wait out WRITE and READ.
  task automatic single_a(input bit idx, input logic [28:0] d);
    if (idx) begin bus_a.req1_data = d; bus_a.req1_valid = 1'b1; end
    else     begin bus_a.req0_data = d; bus_a.req0_valid = 1'b1; end
    @(negedge clk);
    check(idx ? "single_rdy1" : "single_rdy0",
          {63'b0, idx ? bus_a.req1_ready : bus_a.req0_ready}, 64'd1);
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; corrupt = 1'b0;
    bus_a.req0_valid = 1'b0; bus_a.req0_data = '0; bus_a.req1_valid = 1'b0; bus_a.req1_data = '0;
    bus_b.req0_valid = 1'b0; bus_b.req0_data = '0; bus_b.req1_valid = 1'b0; bus_b.req1_data = '0;

    // Reset state, with a request pending that must not be acknowledged.
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b1;
    @(negedge clk);
    check("rst_ready0",     {63'b0, bus_a.req0_ready},     64'd0);
    check("rst_cs",         {63'b0, bus_a.avm_chipselect}, 64'd0);
    check("rst_write_n",    {63'b0, bus_a.avm_write_n},    64'd1);
    check("rst_wdata",      {32'b0, bus_a.avm_writedata},  64'd0);
    check("rst_busy",       {63'b0, busy_a},               64'd0);
    check("rst_last_grant", {63'b0, last_grant_a},         64'd1);
    check("rst_mismatch",   {63'b0, mismatch_a},           64'd0);
    check("rst_wr_count",   {56'b0, wr_count_a},           64'd0);
    bus_a.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;

    // Single request with an echoing slave.
    bus_a.req0_data = 29'h1ABCDEF0; bus_a.req0_valid = 1'b1;
    @(negedge clk);
    check("s_ready0", {63'b0, bus_a.req0_ready}, 64'd1);
    check("s_ready1", {63'b0, bus_a.req1_ready}, 64'd0);
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    bus_a.req0_data  = 29'h0;
    @(negedge clk);
    check("s_write_cs",   {63'b0, bus_a.avm_chipselect}, 64'd1);
    check("s_write_wn",   {63'b0, bus_a.avm_write_n},    64'd0);
    check("s_write_addr", {62'b0, bus_a.avm_address},    64'd0);
    check("s_write_busy", {63'b0, busy_a},               64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_read_cs", {63'b0, bus_a.avm_chipselect}, 64'd1);
    check("s_read_wn", {63'b0, bus_a.avm_write_n},    64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_idle_busy",  {63'b0, busy_a},               64'd0);
    check("s_idle_cs",    {63'b0, bus_a.avm_chipselect}, 64'd0);
    check("s_mismatch",   {63'b0, mismatch_a},           64'd0);
    check("s_wr_count",   {56'b0, wr_count_a},           64'd1);

    // Tie after a fresh reset: req0 first, then strict alternation.
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    grant_q.delete();
    exp_a.delete();
    bus_a.req0_data = 29'h0AAAAAAA; bus_a.req1_data = 29'h15555555;
    bus_a.req0_valid = 1'b1; bus_a.req1_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
    check("tie_grants", grant_q.size(), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < grant_q.size()) check("tie_order", {63'b0, grant_q[i]}, i % 2);
    @(negedge clk);
    check("tie_wr_count", {56'b0, wr_count_a}, 64'd4);
    check("tie_mismatch", {63'b0, mismatch_a}, 64'd0);
    check("tie_last",     {63'b0, last_grant_a}, 64'd1);

    // Readback error, then a clean write that must not clear the flag.
    @(posedge clk); #1;
    corrupt = 1'b1;
    single_a(1'b1, 29'h2);
    @(negedge clk);
    check("err_mismatch", {63'b0, mismatch_a}, 64'd1);
    check("err_wr_count", {56'b0, wr_count_a}, 64'd5);
    @(posedge clk); #1;
    corrupt = 1'b0;
    single_a(1'b0, 29'h3);
    @(negedge clk);
    check("err_sticky",    {63'b0, mismatch_a}, 64'd1);
    check("err_wr_count2", {56'b0, wr_count_a}, 64'd6);

    // Reset in the middle of a WRITE cycle aborts it asynchronously.
    @(posedge clk); #1;
    bus_a.req0_data = 29'h7; bus_a.req0_valid = 1'b1;
    @(negedge clk);
    check("mid_ready0", {63'b0, bus_a.req0_ready}, 64'd1);
    @(posedge clk); #1;
    bus_a.req0_valid = 1'b0;
    #1;
    check("mid_pre_cs", {63'b0, bus_a.avm_chipselect}, 64'd1);
    rst_a = 1'b1;
    #1;
    exp_a.delete();
    check("mid_cs",         {63'b0, bus_a.avm_chipselect}, 64'd0);
    check("mid_wn",         {63'b0, bus_a.avm_write_n},    64'd1);
    check("mid_wdata",      {32'b0, bus_a.avm_writedata},  64'd0);
    check("mid_busy",       {63'b0, busy_a},               64'd0);
    check("mid_wr_count",   {56'b0, wr_count_a},           64'd0);
    check("mid_last_grant", {63'b0, last_grant_a},         64'd1);
    check("mid_mismatch",   {63'b0, mismatch_a},           64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;

    // Write-only instance: req1 held, data changing every cycle, 2-bit saturating counter.
    rst_b = 1'b0;
    @(posedge clk); #1;
    bus_b.req1_data = 29'h100; bus_b.req1_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      check("b_cs_pattern", {63'b0, bus_b.avm_chipselect}, k % 2);
      if (k % 2 == 0)
        check("b_wr_count", {62'b0, wr_count_b}, (k / 2 > 3) ? 3 : k / 2);
      @(posedge clk); #1;
      bus_b.req1_data = 29'h100 + 29'(k + 1);
      if (k == 9) bus_b.req1_valid = 1'b0;
    end
    check("b_mismatch", {63'b0, mismatch_b}, 64'd0);

    check("a_sb_empty", exp_a.size(), 64'd0);
    check("b_sb_empty", exp_b.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
